// File: rtl/dc_token_src.sv
// Writer half of a split dual-clock token FIFO. Words are stored in a register ring, and a one-hot write token is published.
// Latency: a write shows in level_o one cycle later. A destination read shows in level_o 2 edges after read_pointer_i changes.
// Backpressure: ready_o drops when BUFFER_DEPTH-1 words are held or the read pointer is corrupt. It never depends on valid_i.
module dc_token_src #(
  parameter  int DATA_WIDTH   = 32,
  parameter  int BUFFER_DEPTH = 8,
  localparam int LEVEL_WIDTH  = $clog2(BUFFER_DEPTH)
) (
  input  logic                               clk_i,
  input  logic                               rstn_i,
  input  logic                               valid_i,
  input  logic [DATA_WIDTH-1:0]              data_i,
  output logic                               ready_o,
  output logic [BUFFER_DEPTH-1:0]            write_token_o,
  input  logic [BUFFER_DEPTH-1:0]            read_pointer_i,
  output logic [BUFFER_DEPTH*DATA_WIDTH-1:0] data_async_o,
  output logic [LEVEL_WIDTH-1:0]             level_o,
  output logic                               ptr_err_o
);

  logic [BUFFER_DEPTH-1:0]                 r_wtok;
  logic [BUFFER_DEPTH-1:0]                 r_rp_meta;
  logic [BUFFER_DEPTH-1:0]                 r_rp_sync;
  logic [BUFFER_DEPTH-1:0][DATA_WIDTH-1:0] r_slots;
  logic                                    r_ptr_err;

  logic [LEVEL_WIDTH-1:0] w_wr_idx;
  logic [LEVEL_WIDTH-1:0] w_rd_idx;
  logic [LEVEL_WIDTH-1:0] w_level;
  logic                   w_rp_bad;
  logic                   w_ptr_err;
  logic                   w_ready;
  logic                   w_push;

  // One-hot to binary for both pointers. The lowest set bit wins, so a corrupt pointer still decodes deterministically (all-zero gives 0).
  always_comb begin
    w_wr_idx = '0;
    w_rd_idx = '0;
    for (int k = BUFFER_DEPTH - 1; k >= 0; k--) begin
      if (r_wtok[k])    w_wr_idx = k[LEVEL_WIDTH-1:0];
      if (r_rp_sync[k]) w_rd_idx = k[LEVEL_WIDTH-1:0];
    end
  end

  // Occupancy wraps naturally because BUFFER_DEPTH is a power of two. One slot is kept empty to tell full from empty.
  assign w_level   = w_wr_idx - w_rd_idx;
  assign w_rp_bad  = ($countones(r_rp_sync) != 1);
  // The error flag shows as soon as the bad pointer lands in the sync stage. The register keeps it afterwards.
  assign w_ptr_err = r_ptr_err | w_rp_bad;
  assign w_ready   = (w_level != LEVEL_WIDTH'(BUFFER_DEPTH - 1)) && !w_ptr_err;
  assign w_push    = valid_i && w_ready;

  assign ready_o       = w_ready;
  assign write_token_o = r_wtok;
  assign data_async_o  = r_slots;
  assign level_o       = w_level;
  assign ptr_err_o     = w_ptr_err;

  // Two-flop synchronizer for the asynchronous read pointer. There is no logic ahead of the first stage.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_rp_meta <= BUFFER_DEPTH'(1);
      r_rp_sync <= BUFFER_DEPTH'(1);
    end else begin
      r_rp_meta <= read_pointer_i;
      r_rp_sync <= r_rp_meta;
    end
  end

  // Sticky pointer-corruption flag. Only reset clears it.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_ptr_err <= 1'b0;
    end else begin
      r_ptr_err <= r_ptr_err | w_rp_bad;
    end
  end

  // A write loads the addressed slot and rotates the token on the same edge. The far-side synchronizer delay keeps the data settled before the token is seen.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wtok  <= BUFFER_DEPTH'(1);
      r_slots <= '0;
    end else if (w_push) begin
      r_slots[w_wr_idx] <= data_i;
      r_wtok            <= {r_wtok[BUFFER_DEPTH-2:0], r_wtok[BUFFER_DEPTH-1]};
    end
  end

endmodule
